// File: rtl/coffee_pkg.sv
// Shared coffee-machine types: sequencer states, drink encoding and recipe step lengths.
// The coin controller uses the same drink encoding.
package coffee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEAT,
        COFFEE,
        CHOC,
        MILK,
        WATER,
        DONE
    } state_t;

    typedef logic [1:0] drink_t;

    localparam drink_t DRINK_ESPRESSO  = 2'd0;
    localparam drink_t DRINK_AMERICANO = 2'd1;
    localparam drink_t DRINK_LATTE     = 2'd2;
    localparam drink_t DRINK_CHOC      = 2'd3;

    localparam logic [3:0] T_HEAT        = 4'd2;
    localparam logic [3:0] T_COFFEE      = 4'd3;
    localparam logic [3:0] T_CHOC        = 4'd3;
    localparam logic [3:0] T_MILK        = 4'd4;
    localparam logic [3:0] T_WATER_SHORT = 4'd2;
    localparam logic [3:0] T_WATER_LONG  = 4'd5;

    // Lowest-index selected line wins; callers guarantee at least one bit is set.
    function automatic drink_t firstDrink(input logic [3:0] sel);
        if (sel[0])      return DRINK_ESPRESSO;
        else if (sel[1]) return DRINK_AMERICANO;
        else if (sel[2]) return DRINK_LATTE;
        else             return DRINK_CHOC;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Step timer: prescaler divides the clock into ticks, and a 4-bit counter flags the last
// cycle of a step lasting duration ticks. The clear input restarts both counters.
module tick_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] duration,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    ticks_q, ticks_d;
    logic          tickPulse;

    // With TICK_DIV of 1 the prescaler never leaves zero and every cycle is a tick.
    assign tickPulse = (TICK_DIV == 1) ? 1'b1 : (pre_q == PW'(TICK_DIV - 1));
    assign done      = tickPulse && (ticks_q == duration - 4'd1);

    always_comb begin
        pre_d   = pre_q + PW'(1);
        ticks_d = ticks_q;
        if (clear || tickPulse) begin
            pre_d = '0;
        end
        if (clear) begin
            ticks_d = '0;
        end else if (tickPulse) begin
            ticks_d = ticks_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            ticks_q <= '0;
        end else begin
            pre_q   <= pre_d;
            ticks_q <= ticks_d;
        end
    end

endmodule

// File: rtl/drink_sequencer.sv
// Recipe sequencer: latches the drink on a payment edge, steps through the heater and
// valve phases, then pulses readyOut for one cycle back to the coin controller.
module drink_sequencer
    import coffee_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       drink1,
    input  logic       drink2,
    input  logic       drink3,
    input  logic       drink4,
    output logic       readyOut,
    output logic       busy,
    output logic [1:0] drinkCode,
    output logic       heater,
    output logic       waterValve,
    output logic       coffeeValve,
    output logic       milkValve,
    output logic       chocValve
);

    state_t     state_q, state_d;
    drink_t     drink_q, drink_d;
    logic       enable_q;
    logic [3:0] drinkSel;
    logic [3:0] duration;
    logic       timerDone;
    logic       timerClear;
    logic       start;

    assign drinkSel   = {drink4, drink3, drink2, drink1};
    assign start      = (state_q == IDLE) && enable && !enable_q && (drinkSel != 4'd0);
    // Counters sit at zero in IDLE/DONE and restart on every step change.
    assign timerClear = (state_q == IDLE) || (state_q == DONE) || timerDone;

    tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timerClear),
        .duration (duration),
        .done     (timerDone)
    );

    always_comb begin
        duration = T_HEAT;
        case (state_q)
            COFFEE:  duration = T_COFFEE;
            CHOC:    duration = T_CHOC;
            MILK:    duration = T_MILK;
            WATER:   duration = (drink_q == DRINK_AMERICANO) ? T_WATER_LONG : T_WATER_SHORT;
            default: duration = T_HEAT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        drink_d = drink_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HEAT;
                    drink_d = firstDrink(drinkSel);
                end
            end
            HEAT:    if (timerDone) state_d = (drink_q == DRINK_CHOC) ? CHOC : COFFEE;
            COFFEE:  if (timerDone) state_d = (drink_q == DRINK_LATTE) ? MILK : WATER;
            CHOC:    if (timerDone) state_d = MILK;
            MILK:    if (timerDone) state_d = DONE;
            WATER:   if (timerDone) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drink_q     <= DRINK_ESPRESSO;
            enable_q    <= 1'b0;
            readyOut    <= 1'b0;
            busy        <= 1'b0;
            drinkCode   <= 2'd0;
            heater      <= 1'b0;
            waterValve  <= 1'b0;
            coffeeValve <= 1'b0;
            milkValve   <= 1'b0;
            chocValve   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drink_q     <= drink_d;
            enable_q    <= enable;
            readyOut    <= (state_d == DONE);
            busy        <= (state_d != IDLE);
            drinkCode   <= drink_d;
            heater      <= (state_d == HEAT);
            waterValve  <= (state_d == WATER);
            coffeeValve <= (state_d == COFFEE);
            milkValve   <= (state_d == MILK);
            chocValve   <= (state_d == CHOC);
        end
    end

endmodule
